lcd_sequencer: RTL and testbench

HD44780-class character-LCD sequencer that sits between the Nios control logic and the LCD pins (LCD_E, LCD_RS, LCD_RW, LCD_data). It runs the power-on initialisation sequence on its own, then accepts command/data bytes over a valid/ready request port. Each byte is converted into a correctly timed bus cycle: RS/RW setup, E pulse width and hold. After each byte the block waits for the controller's execution time before accepting the next one, so software never has to bit-bang LCD timing.

---
 rtl/lcd_pkg.sv | 46 ++++
 rtl/lcd_sequencer_timer.sv | 37 +++
 rtl/lcd_sequencer.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_lcd_sequencer.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// -----------------------------------------------------------------------------
// lcd_pkg
// Shared definitions for the HD44780-class LCD sequencer:
//   - lcd_state_t  : sequencer FSM states (busy-poll states are only reached
//                    when LCD_BUSY_POLL_EN is defined)
//   - INIT_ROM     : power-on initialisation bytes, index 0 is issued first
//   - command byte constants used by the init ROM
//   - is_long_cmd  : identifies clear/home instructions that need the long
//                    post-write execution wait
// -----------------------------------------------------------------------------
package lcd_pkg;

  typedef enum logic [3:0] {
    ST_PWRUP,
    ST_SETUP,
    ST_EHIGH,
    ST_HOLD,
    ST_EXEC,
    ST_IDLE,
    ST_BSETUP,
    ST_BEHIGH,
    ST_BHOLD
  } lcd_state_t;

  localparam logic [7:0] FUNC_SET_8B2L = 8'h38;
  localparam logic [7:0] DISP_ON       = 8'h0C;
  localparam logic [7:0] CLEAR         = 8'h01;
  localparam logic [7:0] ENTRY_INC     = 8'h06;

  localparam int INIT_LEN = 6;

  // Packed so that INIT_ROM[i] is the i-th byte sent (rightmost = first).
  localparam logic [INIT_LEN-1:0][7:0] INIT_ROM = {
    ENTRY_INC, CLEAR, DISP_ON, FUNC_SET_8B2L, FUNC_SET_8B2L, FUNC_SET_8B2L
  };

  // The first three function-set writes happen before the busy flag is
  // valid, so polling may only start from this ROM index onwards.
  localparam int POLL_FIRST_IDX = 3;

  // Clear display (0x01) and return home (0x02/0x03) need the long wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && (data[7:2] == 6'b000000);
  endfunction

endpackage

// File: rtl/lcd_sequencer_timer.sv
// -----------------------------------------------------------------------------
// lcd_timer
// Loadable down-counter shared by every timed state of the LCD sequencer.
// Loading N makes the zero flag rise N cycles later, so a state that loads
// T-1 on entry and leaves on zero lasts exactly T cycles.
// Ports:
//   clk     in   clock
//   reset_n in   asynchronous active-low reset (count cleared)
//   load    in   load value into the counter this cycle
//   value   in   CNT_W-bit load value
//   zero    out  counter is zero
// -----------------------------------------------------------------------------
module lcd_timer #(
  parameter int CNT_W = 20
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             zero
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= value;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/lcd_sequencer.sv
// -----------------------------------------------------------------------------
// lcd_sequencer
// HD44780-class character-LCD sequencer. Runs the power-on init sequence,
// then turns each accepted command/data byte into a timed bus write
// (setup, E pulse, hold) followed by the controller execution wait.
//
// Optional feature macro: LCD_BUSY_POLL_EN
//   defined   : the execution wait is replaced by busy-flag read cycles
//               (RS=0, RW=1), repeated until LCD_data_in[7] reads 0.
//               PWRUP and the first three init writes keep fixed waits.
//   undefined : fixed T_EXEC / T_CLEAR waits; LCD_RW is always 0 and
//               LCD_data_in is ignored.
//
// Ports:
//   clk          in   clock
//   reset_n      in   asynchronous active-low reset
//   req_valid    in   request present
//   req_rs       in   0 = instruction, 1 = data
//   req_data     in   byte to write
//   req_ready    out  high only while idle; transfer on valid && ready
//   init_done    out  sticky, set once the init sequence has completed
//   busy         out  high whenever not idle
//   LCD_E        out  enable strobe
//   LCD_RS       out  register select
//   LCD_RW       out  0 = write, 1 = read
//   LCD_data_out out  write data
//   LCD_data_oe  out  data pad driver enable
//   LCD_data_in  in   data pad input (busy flag on bit 7)
// -----------------------------------------------------------------------------
module lcd_sequencer
  import lcd_pkg::*;
#(
  parameter int T_AS    = 2,
  parameter int T_PW    = 12,
  parameter int T_H     = 2,
  parameter int T_EXEC  = 2000,
  parameter int T_CLEAR = 82000,
  parameter int T_PWRUP = 750000,
  parameter int CNT_W   = 20
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_valid,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  output logic       req_ready,
  output logic       init_done,
  output logic       busy,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic [7:0] LCD_data_out,
  output logic       LCD_data_oe,
  input  logic [7:0] LCD_data_in
);

  localparam logic [CNT_W-1:0] LD_AS    = CNT_W'(T_AS - 1);
  localparam logic [CNT_W-1:0] LD_PW    = CNT_W'(T_PW - 1);
  localparam logic [CNT_W-1:0] LD_H     = CNT_W'(T_H - 1);
  localparam logic [CNT_W-1:0] LD_EXEC  = CNT_W'(T_EXEC - 1);
  localparam logic [CNT_W-1:0] LD_CLEAR = CNT_W'(T_CLEAR - 1);
  localparam logic [CNT_W-1:0] LD_PWRUP = CNT_W'(T_PWRUP - 1);
  localparam logic [2:0]       IDX_LAST = 3'(INIT_LEN - 1);

  lcd_state_t state_reg, state_next;
  logic [2:0] idx_reg, idx_next;
  logic       init_done_reg, init_done_next;
  logic       armed_reg, armed_next;
  logic       e_reg, e_next;
  logic       rs_reg, rs_next;
  logic       rw_reg, rw_next;
  logic [7:0] data_reg, data_next;
  logic       oe_reg, oe_next;
  logic       byte_done;

  logic             timer_load;
  logic [CNT_W-1:0] timer_value;
  logic             timer_zero;

`ifdef LCD_BUSY_POLL_EN
  logic poll_busy_reg, poll_busy_next;
  logic unused_data_in;
  assign unused_data_in = ^LCD_data_in[6:0];
`else
  logic unused_data_in;
  assign unused_data_in = ^LCD_data_in;
`endif

  lcd_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (timer_load),
    .value   (timer_value),
    .zero    (timer_zero)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= ST_PWRUP;
      idx_reg       <= '0;
      init_done_reg <= 1'b0;
      armed_reg     <= 1'b0;
      e_reg         <= 1'b0;
      rs_reg        <= 1'b0;
      rw_reg        <= 1'b0;
      data_reg      <= 8'h00;
      oe_reg        <= 1'b0;
`ifdef LCD_BUSY_POLL_EN
      poll_busy_reg <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      init_done_reg <= init_done_next;
      armed_reg     <= armed_next;
      e_reg         <= e_next;
      rs_reg        <= rs_next;
      rw_reg        <= rw_next;
      data_reg      <= data_next;
      oe_reg        <= oe_next;
`ifdef LCD_BUSY_POLL_EN
      poll_busy_reg <= poll_busy_next;
`endif
    end
  end

  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    init_done_next = init_done_reg;
    armed_next     = armed_reg;
    e_next         = e_reg;
    rs_next        = rs_reg;
    rw_next        = rw_reg;
    data_next      = data_reg;
    oe_next        = oe_reg;
    timer_load     = 1'b0;
    timer_value    = '0;
    byte_done      = 1'b0;
`ifdef LCD_BUSY_POLL_EN
    poll_busy_next = poll_busy_reg;
`endif

    case (state_reg)
      ST_PWRUP: begin
        // Reset leaves the counter cleared, so the first cycle arms it.
        if (!armed_reg) begin
          armed_next  = 1'b1;
          timer_load  = 1'b1;
          timer_value = LD_PWRUP;
        end else if (timer_zero) begin
          state_next  = ST_SETUP;
          idx_next    = '0;
          rs_next     = 1'b0;
          rw_next     = 1'b0;
          data_next   = INIT_ROM[0];
          oe_next     = 1'b1;
          timer_load  = 1'b1;
          timer_value = LD_AS;
        end
      end

      ST_IDLE: begin
        if (req_valid) begin
          state_next  = ST_SETUP;
          rs_next     = req_rs;
          rw_next     = 1'b0;
          data_next   = req_data;
          oe_next     = 1'b1;
          timer_load  = 1'b1;
          timer_value = LD_AS;
        end
      end

      ST_SETUP: begin
        if (timer_zero) begin
          state_next  = ST_EHIGH;
          e_next      = 1'b1;
          timer_load  = 1'b1;
          timer_value = LD_PW;
        end
      end

      ST_EHIGH: begin
        if (timer_zero) begin
          state_next  = ST_HOLD;
          e_next      = 1'b0;
          timer_load  = 1'b1;
          timer_value = LD_H;
        end
      end

      ST_HOLD: begin
        if (timer_zero) begin
`ifdef LCD_BUSY_POLL_EN
          if (init_done_reg || (idx_reg >= 3'(POLL_FIRST_IDX))) begin
            state_next  = ST_BSETUP;
            rs_next     = 1'b0;
            rw_next     = 1'b1;
            oe_next     = 1'b0;
            timer_load  = 1'b1;
            timer_value = LD_AS;
          end else begin
            state_next  = ST_EXEC;
            oe_next     = 1'b0;
            timer_load  = 1'b1;
            timer_value = is_long_cmd(rs_reg, data_reg) ? LD_CLEAR : LD_EXEC;
          end
`else
          state_next  = ST_EXEC;
          oe_next     = 1'b0;
          timer_load  = 1'b1;
          timer_value = is_long_cmd(rs_reg, data_reg) ? LD_CLEAR : LD_EXEC;
`endif
        end
      end

      ST_EXEC: begin
        if (timer_zero) begin
          byte_done = 1'b1;
        end
      end

`ifdef LCD_BUSY_POLL_EN
      ST_BSETUP: begin
        if (timer_zero) begin
          state_next  = ST_BEHIGH;
          e_next      = 1'b1;
          timer_load  = 1'b1;
          timer_value = LD_PW;
        end
      end

      ST_BEHIGH: begin
        // Busy flag is sampled on the last cycle E is high.
        if (timer_zero) begin
          poll_busy_next = LCD_data_in[7];
          state_next     = ST_BHOLD;
          e_next         = 1'b0;
          timer_load     = 1'b1;
          timer_value    = LD_H;
        end
      end

      ST_BHOLD: begin
        if (timer_zero) begin
          if (poll_busy_reg) begin
            state_next  = ST_BSETUP;
            timer_load  = 1'b1;
            timer_value = LD_AS;
          end else begin
            byte_done = 1'b1;
          end
        end
      end
`endif

      default: begin
        state_next = ST_PWRUP;
        armed_next = 1'b0;
      end
    endcase

    // Shared completion path: either chain the next init byte straight
    // into SETUP or finish in IDLE.
    if (byte_done) begin
      rw_next = 1'b0;
      if (!init_done_reg && (idx_reg != IDX_LAST)) begin
        idx_next    = idx_reg + 3'd1;
        state_next  = ST_SETUP;
        rs_next     = 1'b0;
        data_next   = INIT_ROM[idx_reg + 3'd1];
        oe_next     = 1'b1;
        timer_load  = 1'b1;
        timer_value = LD_AS;
      end else begin
        init_done_next = 1'b1;
        state_next     = ST_IDLE;
      end
    end
  end

  assign req_ready    = (state_reg == ST_IDLE);
  assign busy         = (state_reg != ST_IDLE);
  assign init_done    = init_done_reg;
  assign LCD_E        = e_reg;
  assign LCD_RS       = rs_reg;
  assign LCD_RW       = rw_reg;
  assign LCD_data_out = data_reg;
  assign LCD_data_oe  = oe_reg;

endmodule

// File: tb/tb_lcd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_lcd_sequencer
// Self-checking bench for lcd_sequencer with shortened wait parameters.
// A per-cycle reference model derives every expected pin value from the
// byte being transferred and its offset since the bus cycle started.
// Build with +define+LCD_BUSY_POLL_EN to exercise busy-flag polling.
// -----------------------------------------------------------------------------
module tb_lcd_sequencer;

  localparam int T_AS    = 2;
  localparam int T_PW    = 12;
  localparam int T_H     = 2;
  localparam int T_EXEC  = 40;
  localparam int T_CLEAR = 150;
  localparam int T_PWRUP = 300;
  localparam int CNT_W   = 12;
  localparam int P       = T_AS + T_PW + T_H;
`ifdef LCD_BUSY_POLL_EN
  localparam bit POLL = 1'b1;
  localparam int RDY_NORMAL = 81;   // 1 + 16 + 4 polls * 16
`else
  localparam bit POLL = 1'b0;
  localparam int RDY_NORMAL = 57;   // 1 + 2 + 12 + 2 + 40
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       req_valid;
  logic       req_rs;
  logic [7:0] req_data;
  logic       req_ready;
  logic       init_done;
  logic       busy;
  logic       LCD_E;
  logic       LCD_RS;
  logic       LCD_RW;
  logic [7:0] LCD_data_out;
  logic       LCD_data_oe;
  logic [7:0] LCD_data_in;

  always #5 clk = ~clk;

  lcd_sequencer #(
    .T_AS(T_AS), .T_PW(T_PW), .T_H(T_H), .T_EXEC(T_EXEC),
    .T_CLEAR(T_CLEAR), .T_PWRUP(T_PWRUP), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_rs(req_rs), .req_data(req_data),
    .req_ready(req_ready), .init_done(init_done), .busy(busy),
    .LCD_E(LCD_E), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW),
    .LCD_data_out(LCD_data_out), .LCD_data_oe(LCD_data_oe),
    .LCD_data_in(LCD_data_in)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  // Display model: busy flag reads 1 for three polls, then 0, per byte.
`ifdef LCD_BUSY_POLL_EN
  int   busy_reads = 0;
  logic dev_e_d = 1'b0;
  always @(negedge clk) begin
    if (dev_e_d && !LCD_E && LCD_RW) busy_reads <= (busy_reads == 3) ? 0 : busy_reads + 1;
    dev_e_d <= LCD_E;
  end
  assign LCD_data_in = {(busy_reads < 3), 7'h00};
`else
  always @(posedge clk) LCD_data_in <= 8'($urandom);
`endif

  // ---------------- reference model + compare process ----------------
  logic [7:0] rom [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

  int         mode = 0;          // 0 power-up, 1 byte, 2 idle, 3 accepted
  int         pw_start = -1;
  bit         pw_late = 1'b0;
  int         b_start = 0;
  bit         b_rs = 1'b0;
  logic [7:0] b_data = 8'h00;
  bit         b_init = 1'b0;
  int         b_idx = 0;
  bit         b_poll = 1'b0;
  int         b_wait = 0;
  bit         m_done = 1'b0;
  bit         acc_rs = 1'b0;
  logic [7:0] acc_data = 8'h00;
  logic       p_e = 1'b0, p_rs = 1'b0, p_rw = 1'b0;
  logic [7:0] p_data = 8'h00;
  int         writes_seen = 0, reads_seen = 0, hs_seen = 0;

  task automatic start_byte(input int s, input bit init, input int idx,
                            input bit rs, input logic [7:0] d);
    b_start = s; b_init = init; b_idx = idx; b_rs = rs; b_data = d;
    b_poll  = POLL && (!init || idx >= 3);
    if (b_poll)                 b_wait = 4 * P;
    else if (!rs && d <= 8'h03) b_wait = T_CLEAR;
    else                        b_wait = T_EXEC;
  endtask

  task automatic check_byte();
    int off, sub;
    off = cyc - b_start;
    if (off < P) begin
      chk("byte_oe", int'(LCD_data_oe), 1);
      chk("byte_rs", int'(LCD_RS), int'(b_rs));
      chk("byte_rw", int'(LCD_RW), 0);
      chk("byte_data", int'(LCD_data_out), int'(b_data));
      chk("byte_e", int'(LCD_E), int'(off >= T_AS && off < T_AS + T_PW));
    end else if (b_poll) begin
      sub = (off - P) % P;
      chk("poll_rs", int'(LCD_RS), 0);
      chk("poll_rw", int'(LCD_RW), 1);
      chk("poll_oe", int'(LCD_data_oe), 0);
      chk("poll_e", int'(LCD_E), int'(sub >= T_AS && sub < T_AS + T_PW));
    end else begin
      chk("exec_oe", int'(LCD_data_oe), 0);
      chk("exec_e", int'(LCD_E), 0);
      chk("exec_rs", int'(LCD_RS), int'(b_rs));
      chk("exec_data", int'(LCD_data_out), int'(b_data));
      chk("exec_rw", int'(LCD_RW), 0);
    end
    chk("byte_ready", int'(req_ready), 0);
    chk("byte_busy", int'(busy), 1);
    chk("byte_init_done", int'(init_done), int'(m_done));
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      chk("rst_e", int'(LCD_E), 0);
      chk("rst_rs", int'(LCD_RS), 0);
      chk("rst_rw", int'(LCD_RW), 0);
      chk("rst_data", int'(LCD_data_out), 0);
      chk("rst_oe", int'(LCD_data_oe), 0);
      chk("rst_ready", int'(req_ready), 0);
      chk("rst_busy", int'(busy), 1);
      chk("rst_init_done", int'(init_done), 0);
      mode = 0; pw_start = -1; pw_late = 1'b0; m_done = 1'b0;
    end else begin
      // Bus monitor: no pin change while E is high; capture on E fall.
      if (p_e && LCD_E)
        chk("e_stable", int'({LCD_RS, LCD_RW, LCD_data_out}), int'({p_rs, p_rw, p_data}));
      if (p_e && !LCD_E) begin
        if (!p_rw) begin
          writes_seen++;
          chk("strobe_byte", int'({p_rs, p_data}), int'({b_rs, b_data}));
        end else begin
          reads_seen++;
        end
      end
      if (req_valid && req_ready) hs_seen++;

      if (mode == 0) begin
        if (pw_start < 0) pw_start = cyc;
        if (LCD_data_oe) begin
          chk("pwrup_window", int'(cyc - pw_start >= T_PWRUP && cyc - pw_start <= T_PWRUP + 2), 1);
          mode = 1;
          start_byte(cyc, 1'b1, 0, 1'b0, rom[0]);
        end else begin
          chk("pwrup_e", int'(LCD_E), 0);
          chk("pwrup_ready", int'(req_ready), 0);
          chk("pwrup_busy", int'(busy), 1);
          chk("pwrup_init_done", int'(init_done), 0);
          if (!pw_late && cyc - pw_start > T_PWRUP + 2) begin
            pw_late = 1'b1;
            chk("pwrup_timeout", 0, 1);
          end
        end
      end else if (mode == 3) begin
        mode = 1;
        start_byte(cyc, 1'b0, 0, acc_rs, acc_data);
      end

      if (mode == 1 && cyc - b_start == P + b_wait) begin
        if (b_init && b_idx < 5) start_byte(cyc, 1'b1, b_idx + 1, 1'b0, rom[b_idx + 1]);
        else begin m_done = 1'b1; mode = 2; end
      end

      if (mode == 1) begin
        check_byte();
      end else if (mode == 2) begin
        chk("idle_ready", int'(req_ready), 1);
        chk("idle_busy", int'(busy), 0);
        chk("idle_e", int'(LCD_E), 0);
        chk("idle_oe", int'(LCD_data_oe), 0);
        chk("idle_rw", int'(LCD_RW), 0);
        chk("idle_init_done", int'(init_done), 1);
        if (req_valid) begin
          mode = 3; acc_rs = req_rs; acc_data = req_data;
        end
      end
    end
    p_e = LCD_E; p_rs = LCD_RS; p_rw = LCD_RW; p_data = LCD_data_out;
  end

  // ---------------- stimulus ----------------
  task automatic wait_ready(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
  endtask

  task automatic send(input bit rs, input logic [7:0] d, output int acc);
    bit ok;
    @(posedge clk); #1;
    req_valid = 1'b1; req_rs = rs; req_data = d;
    ok = 1'b0; acc = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; acc = cyc; break; end
    end
    if (!ok) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    $display("tx rs=%0d data=%02h accepted at cycle %0d", rs, d, acc);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int n, hs0, w0, r0;
    bit rs;
    logic [7:0] d;

    reset_n = 1'b0; req_valid = 1'b0; req_rs = 1'b0; req_data = 8'h00;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    wait_ready(T_PWRUP + 1500, ok);
    chk("init_complete", int'(ok), 1);
    chk("init_done_after_init", int'(init_done), 1);
    chk("init_strobes", writes_seen, 6);

    // Literal timing of one data write.
    send(1'b1, 8'h41, n);
    for (int k = 1; k <= RDY_NORMAL; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk("lit_sync", cyc - n, 1);
        chk("lit_rs", int'(LCD_RS), 1);
        chk("lit_data", int'(LCD_data_out), 'h41);
      end
      if (k == 2)  chk("lit_e_before", int'(LCD_E), 0);
      if (k == 3)  chk("lit_e_rise", int'(LCD_E), 1);
      if (k == 14) chk("lit_e_last", int'(LCD_E), 1);
      if (k == 15) chk("lit_e_fall", int'(LCD_E), 0);
      if (k == RDY_NORMAL - 1) chk("lit_ready_early", int'(req_ready), 0);
      if (k == RDY_NORMAL)     chk("lit_ready_back", int'(req_ready), 1);
    end

`ifdef LCD_BUSY_POLL_EN
    r0 = reads_seen;
    send(1'b0, 8'h80, n);
    wait_ready(400, ok);
    chk("poll_done", int'(ok), 1);
    chk("poll_reads", reads_seen - r0, 4);
    chk("poll_total", cyc - n, 81);
`else
    r0 = 0;
    send(1'b0, 8'h01, n);
    wait_ready(400, ok);
    chk("clear_exec_wait", cyc - n - 17, 150);
    send(1'b0, 8'h80, n);
    wait_ready(400, ok);
    chk("addr_exec_wait", cyc - n - 17, 40);
    chk("no_reads", reads_seen + r0, 0);
`endif

    // Four bytes with req_valid held high throughout.
    hs0 = hs_seen; w0 = writes_seen;
    @(posedge clk); #1;
    req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_rs = 1'($urandom); req_data = 8'($urandom);
      ok = 1'b0;
      for (int j = 0; j < 400; j++) begin
        @(negedge clk);
        if (req_ready) begin ok = 1'b1; break; end
      end
      if (!ok) chk("b2b_timeout", 0, 1);
      $display("tx rs=%0d data=%02h back-to-back at cycle %0d", req_rs, req_data, cyc);
      @(posedge clk); #1;
      if (i == 3) req_valid = 1'b0;
    end
    wait_ready(400, ok);
    chk("b2b_handshakes", hs_seen - hs0, 4);
    chk("b2b_strobes", writes_seen - w0, 4);

    // Random traffic, biased toward the clear/home boundary commands.
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 4)) @(posedge clk);
      rs = 1'($urandom);
      d  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom);
      send(rs, d, n);
    end
    wait_ready(400, ok);
    chk("random_drain", int'(ok), 1);

    // Reset during the E pulse.
    send(1'b1, 8'h55, n);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (LCD_E) begin ok = 1'b1; break; end
    end
    chk("e_seen_before_reset", int'(ok), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_e", int'(LCD_E), 0);
    chk("async_oe", int'(LCD_data_oe), 0);
    chk("async_rs", int'(LCD_RS), 0);
    chk("async_data", int'(LCD_data_out), 0);
    chk("async_busy", int'(busy), 1);
    chk("async_init_done", int'(init_done), 0);
    $display("tx reset asserted during E at cycle %0d", cyc);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    w0 = writes_seen;
    wait_ready(T_PWRUP + 1500, ok);
    chk("reinit_complete", int'(ok), 1);
    chk("reinit_strobes", writes_seen - w0, 6);
    chk("reinit_done", int'(init_done), 1);

    send(1'b1, 8'h7E, n);
    wait_ready(400, ok);
    chk("final_ready", int'(ok), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
